// File: rtl/mon_packet_tx.sv
// mon_packet_tx: serialises 40-bit words onto a single idle-high line toward
// the monitor-side receiver. Each frame is one low start bit followed by 40
// data bits MSB first, and then at least GAP idle-high cycles before the next
// start bit.
// Optional feature: define MON_PACKET_TX_FIFO_EN to replace the single holding
// register in front of the serialiser with a 4-entry FIFO.
module mon_packet_tx #(
  parameter int GAP = 8  // idle-high cycles between frames, 1..255
) (
  input  logic        mon_clk,
  input  logic        reset,
  input  logic [39:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        to_mon,
  output logic        busy,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  // Loaded on entry to GAP; GAP reaches zero after exactly GAP cycles.
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  // Queue interface seen by the serialiser.
  logic        push;
  logic        deq;
  logic        q_empty;
  logic [39:0] q_head;

  assign push = in_valid & in_ready;

`ifdef MON_PACKET_TX_FIFO_EN
  logic [39:0] fifo_mem [0:3];
  logic [1:0]  wr_ptr_reg;
  logic [1:0]  rd_ptr_reg;
  logic [2:0]  count_reg;

  // FIFO storage: written on accept, no reset needed for the data itself.
  always_ff @(posedge mon_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_data;
    end
  end

  // FIFO pointers and occupancy; push and pop in the same cycle leave count alone.
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
      case ({push, deq})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign in_ready = (count_reg != 3'd4);
  assign q_empty  = (count_reg == 3'd0);
  assign q_head   = fifo_mem[rd_ptr_reg];
`else
  logic [39:0] hold_reg;
  logic        hold_valid_reg;

  // Single holding register; it cannot accept while occupied, so push and
  // dequeue never coincide.
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      hold_reg       <= 40'd0;
      hold_valid_reg <= 1'b0;
    end else if (push) begin
      hold_reg       <= in_data;
      hold_valid_reg <= 1'b1;
    end else if (deq) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign in_ready = ~hold_valid_reg;
  assign q_empty  = ~hold_valid_reg;
  assign q_head   = hold_reg;
`endif

  state_t      state_reg, state_next;
  logic [39:0] shift_reg, shift_next;
  logic        to_mon_reg, to_mon_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [15:0] pkt_count_reg, pkt_count_next;

  // Serialiser state and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      shift_reg     <= 40'd0;
      to_mon_reg    <= 1'b1;
      bit_cnt_reg   <= 6'd0;
      gap_cnt_reg   <= 8'd0;
      pkt_count_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      to_mon_reg    <= to_mon_next;
      bit_cnt_reg   <= bit_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      pkt_count_reg <= pkt_count_next;
    end
  end

  // Next-state and line value; the last GAP cycle may go straight to START
  // so back-to-back frames are separated by exactly GAP high cycles.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    to_mon_next    = to_mon_reg;
    bit_cnt_next   = bit_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    pkt_count_next = pkt_count_reg;
    deq            = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!q_empty) begin
          deq         = 1'b1;
          shift_next  = q_head;
          to_mon_next = 1'b0;
          state_next  = S_START;
        end
      end
      S_START: begin
        to_mon_next  = shift_reg[39];
        shift_next   = {shift_reg[38:0], 1'b0};
        bit_cnt_next = 6'd39;
        state_next   = S_DATA;
      end
      S_DATA: begin
        if (bit_cnt_reg == 6'd0) begin
          to_mon_next    = 1'b1;
          gap_cnt_next   = GAP_LAST;
          pkt_count_next = pkt_count_reg + 16'd1;
          state_next     = S_GAP;
        end else begin
          to_mon_next  = shift_reg[39];
          shift_next   = {shift_reg[38:0], 1'b0};
          bit_cnt_next = bit_cnt_reg - 6'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == 8'd0) begin
          if (!q_empty) begin
            deq         = 1'b1;
            shift_next  = q_head;
            to_mon_next = 1'b0;
            state_next  = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign to_mon    = to_mon_reg;
  assign busy      = (state_reg != S_IDLE);
  assign pkt_count = pkt_count_reg;

endmodule
